// File: rtl/sha2_msg_sched.sv
// sha2_msg_sched: SHA-2 message-schedule engine.
// Buffers one 16-word block in a circular register file and streams
// W[0..R-1] to the round datapath. SHA-256 (32-bit words, 64 rounds) or
// SHA-512 (64-bit words, 80 rounds), selected per block by 'mode' at start.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   start, mode         begin a block (IDLE only); mode 0=SHA-256, 1=SHA-512
//   in_valid/in_ready   message word handshake, in_data MSW-first
//   out_valid/out_ready schedule word handshake, out_data=W[t], out_idx=t
//   busy                engine not in IDLE
//   done                one-cycle pulse after the last W is accepted
module sha2_msg_sched #(
  parameter int WIDTH  = 64,
  parameter int EN_512 = 1,
  parameter int DEPTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [6:0]       out_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state, state_n;

  logic             mode_r;
  logic [3:0]       lcnt;
  logic [6:0]       t;
  logic [WIDTH-1:0] wbuf [DEPTH];

  // ---------------- sigma functions ----------------
  function automatic logic [31:0] s0_256(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1_256(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] s0_512(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] s1_512(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  // ---------------- control ----------------
  logic       mode_eff;
  logic [6:0] rounds;
  logic [6:0] last_idx;
  logic       out_fire;
  logic       load_out;
  logic       last_acc;
  logic       we_load;
  logic       we_run;

  assign mode_eff = (EN_512 != 0) ? mode_r : 1'b0;
  assign rounds   = mode_eff ? 7'd80 : 7'd64;
  assign last_idx = rounds - 7'd1;
  assign out_fire = out_valid & out_ready;
  // Output register refills when empty or drained this cycle; t==rounds
  // means every W has already been issued.
  assign load_out = (state == RUN) && (!out_valid || out_ready) && (t != rounds);
  assign last_acc = (state == RUN) && out_fire && (out_idx == last_idx);
  assign we_load  = (state == LOAD) && in_valid;
  assign we_run   = load_out && (t >= 7'd16);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && lcnt == 4'd15) state_n = RUN;
      end
      RUN: begin
        if (last_acc) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------- schedule datapath ----------------
  logic [3:0]  i2, i7, i15, i16;
  logic [63:0] b2, b7, b15, b16;
  logic [31:0] w32;
  logic [63:0] w64, w_new, w_out;
  logic [63:0] in64, wr64;

  // 4-bit wrap-around indexing into the circular buffer; t-15 == t+1 mod 16.
  assign i2  = t[3:0] - 4'd2;
  assign i7  = t[3:0] - 4'd7;
  assign i15 = t[3:0] - 4'd15;
  assign i16 = t[3:0];

  assign b2  = 64'(wbuf[i2]);
  assign b7  = 64'(wbuf[i7]);
  assign b15 = 64'(wbuf[i15]);
  assign b16 = 64'(wbuf[i16]);

  assign w32   = s1_256(b2[31:0]) + b7[31:0] + s0_256(b15[31:0]) + b16[31:0];
  assign w64   = s1_512(b2) + b7 + s0_512(b15) + b16;
  assign w_new = mode_eff ? w64 : {32'b0, w32};
  // First 16 words come straight from the buffer (already masked on load).
  assign w_out = (t < 7'd16) ? b16 : w_new;

  assign in64 = 64'(in_data);
  assign wr64 = mode_eff ? in64 : {32'b0, in64[31:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r    <= 1'b0;
      lcnt      <= '0;
      t         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_r <= (EN_512 != 0) ? mode : 1'b0;
            lcnt   <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            lcnt <= lcnt + 4'd1;
            if (lcnt == 4'd15) t <= '0;
          end
        end
        RUN: begin
          if (load_out) begin
            out_data  <= WIDTH'(w_out);
            out_idx   <= t;
            out_valid <= 1'b1;
            t         <= t + 7'd1;
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
          if (last_acc) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Buffer is deliberately not reset; writes are still blocked during reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (we_load)     wbuf[lcnt] <= WIDTH'(wr64);
      else if (we_run) wbuf[i16]  <= WIDTH'(w_new);
    end
  end

endmodule

// File: tb/tb_sha2_msg_sched.sv
module tb_sha2_msg_sched;

  logic        clk = 1'b0;
  logic        rst_n, start, mode, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [63:0] in_data, out_data;
  logic [6:0]  out_idx;

  always #5 clk = ~clk;

  sha2_msg_sched #(.WIDTH(64), .EN_512(1), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] blk256 [16];
  logic [63:0] blk512 [16];
  logic [63:0] ref256 [64];
  logic [63:0] ref512 [80];

  logic [63:0] got_data [80];
  int          got_idx  [80];
  int          got_cyc  [80];
  int          n_got, done_cnt, n_hold;
  logic [63:0] hold_data [8];
  int          hold_idx  [8];
  logic [31:0] upper_or;

  // ---------------- reference schedule (plain linear recurrence) ----------
  function automatic logic [31:0] r0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] r1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction
  function automatic logic [63:0] q0(input logic [63:0] x);
    return ((x >> 1) | (x << 63)) ^ ((x >> 8) | (x << 56)) ^ (x >> 7);
  endfunction
  function automatic logic [63:0] q1(input logic [63:0] x);
    return ((x >> 19) | (x << 45)) ^ ((x >> 61) | (x << 3)) ^ (x >> 6);
  endfunction

  task automatic build_refs();
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      blk256[i] = 64'h0;
      blk512[i] = 64'h0;
    end
    blk256[0]  = 64'h0000_0000_6162_6380;
    blk256[15] = 64'h0000_0000_0000_0018;
    blk512[0]  = 64'h6162_6380_0000_0000;
    blk512[15] = 64'h0000_0000_0000_0018;
    for (int i = 0; i < 16; i++) begin
      ref256[i] = blk256[i];
      ref512[i] = blk512[i];
    end
    for (int i = 16; i < 64; i++) begin
      a = r1(ref256[i-2][31:0]) + ref256[i-7][31:0] + r0(ref256[i-15][31:0]) + ref256[i-16][31:0];
      ref256[i] = {32'h0, a};
    end
    for (int i = 16; i < 80; i++)
      ref512[i] = q1(ref512[i-2]) + ref512[i-7] + q0(ref512[i-15]) + ref512[i-16];
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic load_block(input logic m, input bit gaps, input bit mid_start,
                            input bit hi_garbage, output int acc);
    int cyc;
    logic [63:0] w;
    start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 16 && cyc < 200) begin
      w = m ? blk512[acc] : blk256[acc];
      if (hi_garbage) w[63:32] = 32'hFFFF_FFFF;
      in_valid = gaps ? (cyc % 2 == 1) : 1'b1;
      in_data  = w;
      if (mid_start && cyc == 6) begin start = 1'b1; mode = ~m; end
      else begin start = 1'b0; mode = 1'b0; end
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0; mode = 1'b0;
  endtask

  task automatic drain(input int rcount, input int max_cyc, input int stall_idx, input int stall_len);
    int cyc, extra, stall_cnt;
    for (int i = 0; i < 80; i++) begin got_data[i] = 'x; got_idx[i] = -1; got_cyc[i] = -1; end
    n_got = 0; done_cnt = 0; n_hold = 0; upper_or = '0;
    cyc = 0; extra = 0; stall_cnt = 0;
    while (cyc < max_cyc && extra < 4) begin
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1 && int'(out_idx) == stall_idx && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        hold_data[n_hold] = out_data; hold_idx[n_hold] = int'(out_idx);
        n_hold++; stall_cnt++;
      end else out_ready = 1'b1;
      if (out_valid === 1'b1) upper_or |= out_data[63:32];
      if (out_valid === 1'b1 && out_ready && n_got < 80) begin
        got_data[n_got] = out_data; got_idx[n_got] = int'(out_idx); got_cyc[n_got] = cyc;
        n_got++;
      end
      if (n_got >= rcount) extra++;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (out_data !== 64'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_idx !== 7'h0) begin failures++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sha256_abc();
    int acc;
    load_block(1'b0, 1'b0, 1'b0, 1'b0, acc);
    checks++; if (acc !== 16) begin failures++; $display("FAIL s256_load_count got=%0d exp=16", acc); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL s256_in_ready_drop got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL s256_busy_run got=%b exp=1", busy); end
    drain(64, 400, -1, 0);
    checks++; if (n_got !== 64) begin failures++; $display("FAIL s256_word_count got=%0d exp=64", n_got); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (got_idx[i] !== i) begin failures++; $display("FAIL s256_idx[%0d] got=%0d exp=%0d", i, got_idx[i], i); end
      checks++; if (got_data[i] !== ref256[i]) begin failures++; $display("FAIL s256_W[%0d] got=%h exp=%h", i, got_data[i], ref256[i]); end
    end
    for (int i = 1; i < 64; i++) begin
      checks++; if (got_cyc[i] !== got_cyc[i-1] + 1) begin failures++; $display("FAIL s256_consecutive[%0d] got=%0d exp=%0d", i, got_cyc[i], got_cyc[i-1] + 1); end
    end
    checks++; if (got_data[16] !== 64'h6162_6380) begin failures++; $display("FAIL s256_W16 got=%h exp=61626380", got_data[16]); end
    checks++; if (got_data[17] !== 64'h000F_0000) begin failures++; $display("FAIL s256_W17 got=%h exp=000f0000", got_data[17]); end
    checks++; if (got_data[18] !== 64'h7DA8_6405) begin failures++; $display("FAIL s256_W18 got=%h exp=7da86405", got_data[18]); end
    checks++; if (got_data[19] !== 64'h6000_03C6) begin failures++; $display("FAIL s256_W19 got=%h exp=600003c6", got_data[19]); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL s256_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL s256_busy_after got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL s256_out_valid_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_sha512_abc();
    int acc;
    load_block(1'b1, 1'b0, 1'b0, 1'b0, acc);
    checks++; if (acc !== 16) begin failures++; $display("FAIL s512_load_count got=%0d exp=16", acc); end
    drain(80, 400, -1, 0);
    checks++; if (n_got !== 80) begin failures++; $display("FAIL s512_word_count got=%0d exp=80", n_got); end
    for (int i = 0; i < 80; i++) begin
      checks++; if (got_idx[i] !== i) begin failures++; $display("FAIL s512_idx[%0d] got=%0d exp=%0d", i, got_idx[i], i); end
      checks++; if (got_data[i] !== ref512[i]) begin failures++; $display("FAIL s512_W[%0d] got=%h exp=%h", i, got_data[i], ref512[i]); end
    end
    checks++; if (got_data[16] !== 64'h6162_6380_0000_0000) begin failures++; $display("FAIL s512_W16 got=%h exp=6162638000000000", got_data[16]); end
    checks++; if (got_data[17] !== 64'h0003_0000_0000_00C0) begin failures++; $display("FAIL s512_W17 got=%h exp=00030000000000c0", got_data[17]); end
    checks++; if (got_idx[79] !== 79) begin failures++; $display("FAIL s512_last_idx got=%0d exp=79", got_idx[79]); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL s512_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL s512_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    int acc;
    load_block(1'b0, 1'b0, 1'b0, 1'b0, acc);
    drain(64, 400, 16, 5);
    checks++; if (n_hold !== 5) begin failures++; $display("FAIL bp_hold_cycles got=%0d exp=5", n_hold); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (hold_data[k] !== 64'h6162_6380) begin failures++; $display("FAIL bp_hold_data[%0d] got=%h exp=61626380", k, hold_data[k]); end
      checks++; if (hold_idx[k] !== 16) begin failures++; $display("FAIL bp_hold_idx[%0d] got=%0d exp=16", k, hold_idx[k]); end
    end
    checks++; if (n_got !== 64) begin failures++; $display("FAIL bp_word_count got=%0d exp=64", n_got); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (got_idx[i] !== i) begin failures++; $display("FAIL bp_idx[%0d] got=%0d exp=%0d", i, got_idx[i], i); end
      checks++; if (got_data[i] !== ref256[i]) begin failures++; $display("FAIL bp_W[%0d] got=%h exp=%h", i, got_data[i], ref256[i]); end
    end
    checks++; if (got_data[17] !== 64'h000F_0000) begin failures++; $display("FAIL bp_W17 got=%h exp=000f0000", got_data[17]); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_load_gaps();
    int acc;
    load_block(1'b0, 1'b1, 1'b1, 1'b0, acc);
    checks++; if (acc !== 16) begin failures++; $display("FAIL gap_load_count got=%0d exp=16", acc); end
    // Extra offered word while in RUN must be refused.
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_DEAD_BEEF;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL gap_in_ready_after16 got=%b exp=0", in_ready); end
    drain(64, 400, -1, 0);
    in_valid = 1'b0;
    checks++; if (n_got !== 64) begin failures++; $display("FAIL gap_word_count got=%0d exp=64", n_got); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (got_data[i] !== ref256[i]) begin failures++; $display("FAIL gap_W[%0d] got=%h exp=%h", i, got_data[i], ref256[i]); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL gap_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_mask();
    int acc;
    load_block(1'b0, 1'b0, 1'b0, 1'b1, acc);
    drain(64, 400, -1, 0);
    checks++; if (n_got !== 64) begin failures++; $display("FAIL mask_word_count got=%0d exp=64", n_got); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (got_data[i] !== ref256[i]) begin failures++; $display("FAIL mask_W[%0d] got=%h exp=%h", i, got_data[i], ref256[i]); end
    end
    checks++; if (upper_or !== 32'h0) begin failures++; $display("FAIL mask_upper_bits got=%h exp=0", upper_or); end
  endtask

  task automatic test_reset_mid();
    int acc, cyc;
    load_block(1'b0, 1'b0, 1'b0, 1'b0, acc);
    out_ready = 1'b1; cyc = 0;
    while (!(out_valid === 1'b1 && out_idx == 7'd30) && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    checks++; if (cyc >= 200) begin failures++; $display("FAIL rst_mid_reach_t30 got=timeout exp=idx30"); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    checks++; if (out_idx !== 7'd0) begin failures++; $display("FAIL rst_mid_out_idx got=%0d exp=0", out_idx); end
    load_block(1'b0, 1'b0, 1'b0, 1'b0, acc);
    drain(64, 400, -1, 0);
    checks++; if (n_got !== 64) begin failures++; $display("FAIL rst_fresh_word_count got=%0d exp=64", n_got); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (got_idx[i] !== i) begin failures++; $display("FAIL rst_fresh_idx[%0d] got=%0d exp=%0d", i, got_idx[i], i); end
      checks++; if (got_data[i] !== ref256[i]) begin failures++; $display("FAIL rst_fresh_W[%0d] got=%h exp=%h", i, got_data[i], ref256[i]); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rst_fresh_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    build_refs();
    test_reset();
    test_sha256_abc();
    test_sha512_abc();
    test_backpressure();
    test_load_gaps();
    test_mask();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
